// File: rtl/time_set_ctrl.sv
// time_set_ctrl: keyboard-driven editor for the clock time.
// Snapshots the running time on entry to set mode, lets the arrow keys pick
// and adjust the hour, minute or second field in BCD, and emits a single
// load strobe with the edited time when set mode is left.

module time_set_ctrl #(
    parameter int unsigned BLINK_HALF = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       settime,
    input  logic       left_key,
    input  logic       right_key,
    input  logic       up_key,
    input  logic       down_key,
    input  logic [3:0] cur_secMSB,
    input  logic [3:0] cur_secLSB,
    input  logic [3:0] cur_minMSB,
    input  logic [3:0] cur_minLSB,
    input  logic [3:0] cur_hourMSB,
    input  logic [3:0] cur_hourLSB,
    output logic [3:0] set_secMSB,
    output logic [3:0] set_secLSB,
    output logic [3:0] set_minMSB,
    output logic [3:0] set_minLSB,
    output logic [3:0] set_hourMSB,
    output logic [3:0] set_hourLSB,
    output logic [1:0] field_sel,
    output logic       editing,
    output logic       blink,
    output logic       load
);

    localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        IDLE,
        EDIT,
        COMMIT
    } state_t;

    state_t           state;
    logic             settime_q;
    logic             rise_pending;
    logic [CNT_W-1:0] blink_cnt;

    logic       rise;
    logic       fall;
    logic       any_key;
    logic [3:0] sel_msb;
    logic [3:0] sel_lsb;
    logic [3:0] max_msb;
    logic [3:0] max_lsb;
    logic [7:0] adj_field;
    logic [1:0] next_field_sel;

    assign rise    = settime & ~settime_q;
    assign fall    = ~settime & settime_q;
    assign any_key = left_key | right_key | up_key | down_key;

    // Two-digit BCD value, forced to 00 when a digit is not BCD or the value exceeds the field maximum.
    function automatic logic [7:0] bcd_clean(input logic [3:0] msb, input logic [3:0] lsb,
                                             input logic [3:0] mx_msb, input logic [3:0] mx_lsb);
        if (msb > 4'd9 || lsb > 4'd9)
            return 8'h00;
        if (msb > mx_msb)
            return 8'h00;
        if (msb == mx_msb && lsb > mx_lsb)
            return 8'h00;
        return {msb, lsb};
    endfunction

    // Increment with wrap from the field maximum back to 00.
    function automatic logic [7:0] bcd_up(input logic [3:0] msb, input logic [3:0] lsb,
                                          input logic [3:0] mx_msb, input logic [3:0] mx_lsb);
        if (msb == mx_msb && lsb == mx_lsb)
            return 8'h00;
        if (lsb >= 4'd9)
            return {msb + 4'd1, 4'd0};
        return {msb, lsb + 4'd1};
    endfunction

    // Decrement with wrap from 00 up to the field maximum.
    function automatic logic [7:0] bcd_down(input logic [3:0] msb, input logic [3:0] lsb,
                                            input logic [3:0] mx_msb, input logic [3:0] mx_lsb);
        if (msb == 4'd0 && lsb == 4'd0)
            return {mx_msb, mx_lsb};
        if (lsb == 4'd0)
            return {msb - 4'd1, 4'd9};
        return {msb, lsb - 4'd1};
    endfunction

    // Pick the selected field, compute its adjusted value and the next field selection.
    always_comb begin
        sel_msb = set_secMSB;
        sel_lsb = set_secLSB;
        max_msb = 4'd5;
        max_lsb = 4'd9;
        case (field_sel)
            2'd1: begin
                sel_msb = set_minMSB;
                sel_lsb = set_minLSB;
            end
            2'd2: begin
                sel_msb = set_hourMSB;
                sel_lsb = set_hourLSB;
                max_msb = 4'd2;
                max_lsb = 4'd3;
            end
            default: ;
        endcase

        adj_field = {sel_msb, sel_lsb};
        if (up_key && !down_key)
            adj_field = bcd_up(sel_msb, sel_lsb, max_msb, max_lsb);
        else if (down_key && !up_key)
            adj_field = bcd_down(sel_msb, sel_lsb, max_msb, max_lsb);

        next_field_sel = field_sel;
        if (left_key && !right_key)
            next_field_sel = (field_sel == 2'd2) ? 2'd0 : field_sel + 2'd1;
        else if (right_key && !left_key)
            next_field_sel = (field_sel == 2'd0) ? 2'd2 : field_sel - 2'd1;
    end

    // Edit state machine with registered outputs, edited time and blink timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            settime_q    <= 1'b0;
            rise_pending <= 1'b0;
            blink_cnt    <= '0;
            set_secMSB   <= 4'd0;
            set_secLSB   <= 4'd0;
            set_minMSB   <= 4'd0;
            set_minLSB   <= 4'd0;
            set_hourMSB  <= 4'd0;
            set_hourLSB  <= 4'd0;
            field_sel    <= 2'd0;
            editing      <= 1'b0;
            blink        <= 1'b0;
            load         <= 1'b0;
        end else begin
            settime_q <= settime;
            load      <= 1'b0;
            case (state)
                IDLE: begin
                    editing      <= 1'b0;
                    blink        <= 1'b0;
                    rise_pending <= 1'b0;
                    if (settime && (!settime_q || rise_pending)) begin
                        {set_secMSB, set_secLSB}   <= bcd_clean(cur_secMSB, cur_secLSB, 4'd5, 4'd9);
                        {set_minMSB, set_minLSB}   <= bcd_clean(cur_minMSB, cur_minLSB, 4'd5, 4'd9);
                        {set_hourMSB, set_hourLSB} <= bcd_clean(cur_hourMSB, cur_hourLSB, 4'd2, 4'd3);
                        field_sel <= 2'd0;
                        blink_cnt <= '0;
                        blink     <= 1'b1;
                        editing   <= 1'b1;
                        state     <= EDIT;
                    end
                end
                EDIT: begin
                    editing   <= 1'b1;
                    field_sel <= next_field_sel;
                    case (field_sel)
                        2'd0:    {set_secMSB, set_secLSB}   <= adj_field;
                        2'd1:    {set_minMSB, set_minLSB}   <= adj_field;
                        2'd2:    {set_hourMSB, set_hourLSB} <= adj_field;
                        default: ;
                    endcase
                    if (any_key) begin
                        blink_cnt <= '0;
                        blink     <= 1'b1;
                    end else if (blink_cnt == CNT_LAST) begin
                        blink_cnt <= '0;
                        blink     <= ~blink;
                    end else begin
                        blink_cnt <= blink_cnt + CNT_W'(1);
                    end
                    if (fall)
                        state <= COMMIT;
                end
                COMMIT: begin
                    load         <= 1'b1;
                    editing      <= 1'b0;
                    blink        <= 1'b0;
                    rise_pending <= rise;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: scenario tasks plus a randomized edit session checked
// against an integer model of the clock fields.

module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       settime = 1'b0;
    logic       left_key = 1'b0;
    logic       right_key = 1'b0;
    logic       up_key = 1'b0;
    logic       down_key = 1'b0;
    logic [3:0] cur_secMSB = 4'd0;
    logic [3:0] cur_secLSB = 4'd0;
    logic [3:0] cur_minMSB = 4'd0;
    logic [3:0] cur_minLSB = 4'd0;
    logic [3:0] cur_hourMSB = 4'd0;
    logic [3:0] cur_hourLSB = 4'd0;
    logic [3:0] set_secMSB;
    logic [3:0] set_secLSB;
    logic [3:0] set_minMSB;
    logic [3:0] set_minLSB;
    logic [3:0] set_hourMSB;
    logic [3:0] set_hourLSB;
    logic [1:0] field_sel;
    logic       editing;
    logic       blink;
    logic       load;

    int total = 0;
    int bad = 0;

    // Reference model: plain integer fields, selected field and cycles since the blink restart.
    int m_h, m_m, m_s, m_fs, m_n;

    time_set_ctrl #(.BLINK_HALF(4)) dut (
        .clk(clk), .reset(reset), .settime(settime),
        .left_key(left_key), .right_key(right_key), .up_key(up_key), .down_key(down_key),
        .cur_secMSB(cur_secMSB), .cur_secLSB(cur_secLSB),
        .cur_minMSB(cur_minMSB), .cur_minLSB(cur_minLSB),
        .cur_hourMSB(cur_hourMSB), .cur_hourLSB(cur_hourLSB),
        .set_secMSB(set_secMSB), .set_secLSB(set_secLSB),
        .set_minMSB(set_minMSB), .set_minLSB(set_minLSB),
        .set_hourMSB(set_hourMSB), .set_hourLSB(set_hourLSB),
        .field_sel(field_sel), .editing(editing), .blink(blink), .load(load)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pack_time(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int sanit(input int msb, input int lsb, input int mx);
        if (msb > 9 || lsb > 9 || msb * 10 + lsb > mx)
            return 0;
        return msb * 10 + lsb;
    endfunction

    function automatic logic [23:0] dut_time();
        return {set_hourMSB, set_hourLSB, set_minMSB, set_minLSB, set_secMSB, set_secLSB};
    endfunction

    function automatic logic exp_blink();
        return ((m_n / 4) % 2) == 0;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cur(input int hm, input int hl, input int mm, input int ml,
                           input int sm, input int sl);
        cur_hourMSB = 4'(hm); cur_hourLSB = 4'(hl);
        cur_minMSB  = 4'(mm); cur_minLSB  = 4'(ml);
        cur_secMSB  = 4'(sm); cur_secLSB  = 4'(sl);
    endtask

    // Raise settime for one edge and load the model with the sanitised snapshot.
    task automatic enter_edit();
        settime = 1'b1;
        cycle();
        m_h  = sanit(int'(cur_hourMSB), int'(cur_hourLSB), 23);
        m_m  = sanit(int'(cur_minMSB), int'(cur_minLSB), 59);
        m_s  = sanit(int'(cur_secMSB), int'(cur_secLSB), 59);
        m_fs = 0;
        m_n  = 0;
    endtask

    // Pulse the given keys for one edge and advance the model accordingly.
    task automatic key_cycle(input logic l, input logic r, input logic u, input logic d);
        left_key = l; right_key = r; up_key = u; down_key = d;
        cycle();
        left_key = 1'b0; right_key = 1'b0; up_key = 1'b0; down_key = 1'b0;
        if (u && !d) begin
            case (m_fs)
                0: m_s = (m_s + 1) % 60;
                1: m_m = (m_m + 1) % 60;
                default: m_h = (m_h + 1) % 24;
            endcase
        end else if (d && !u) begin
            case (m_fs)
                0: m_s = (m_s + 59) % 60;
                1: m_m = (m_m + 59) % 60;
                default: m_h = (m_h + 23) % 24;
            endcase
        end
        if (l && !r)
            m_fs = (m_fs + 1) % 3;
        else if (r && !l)
            m_fs = (m_fs + 2) % 3;
        if (l || r || u || d)
            m_n = 0;
        else
            m_n++;
    endtask

    task automatic quiet_exit();
        settime = 1'b0;
        cycle();
        cycle();
        cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        total++;
        if ({dut_time(), field_sel, editing, blink, load} !== 29'd0) begin
            bad++;
            $display("[TB] FAIL reset_state: got time=%h fs=%0d ed=%b bl=%b ld=%b, want all zero",
                     dut_time(), field_sel, editing, blink, load);
        end
        reset = 1'b0;
        cycle();

        set_cur(1, 2, 3, 4, 5, 6);
        enter_edit();
        key_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (dut_time() !== pack_time(12, 34, 56) || editing !== 1'b1) begin
            bad++;
            $display("[TB] FAIL pre_reset_edit: got time=%h ed=%b, want 123456 ed=1", dut_time(), editing);
        end
        reset = 1'b1;
        settime = 1'b0;
        cycle();
        total++;
        if ({dut_time(), field_sel, editing, blink, load} !== 29'd0) begin
            bad++;
            $display("[TB] FAIL mid_edit_reset: got time=%h fs=%0d ed=%b bl=%b ld=%b, want all zero",
                     dut_time(), field_sel, editing, blink, load);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (load !== 1'b0 || editing !== 1'b0) begin
                bad++;
                $display("[TB] FAIL post_reset_quiet: got ld=%b ed=%b, want 0 0", load, editing);
            end
        end
    endtask

    task automatic test_rollover();
        set_cur(2, 3, 5, 9, 5, 8);
        enter_edit();
        total++;
        if (editing !== 1'b1 || dut_time() !== pack_time(23, 59, 58) || field_sel !== 2'd0 || blink !== 1'b1) begin
            bad++;
            $display("[TB] FAIL snapshot: got ed=%b time=%h fs=%0d bl=%b, want 1 235958 0 1",
                     editing, dut_time(), field_sel, blink);
        end
        key_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        if (dut_time() !== pack_time(23, 59, 59)) begin
            bad++;
            $display("[TB] FAIL sec_up: got %h, want 235959", dut_time());
        end
        key_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        if (dut_time() !== pack_time(23, 59, 0)) begin
            bad++;
            $display("[TB] FAIL sec_wrap: got %h, want 235900", dut_time());
        end
        quiet_exit();
    endtask

    task automatic test_field_nav();
        set_cur(1, 0, 0, 0, 0, 9);
        enter_edit();
        key_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (field_sel !== 2'd1) begin
            bad++;
            $display("[TB] FAIL nav_left1: got fs=%0d, want 1", field_sel);
        end
        key_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (dut_time() !== pack_time(10, 59, 9)) begin
            bad++;
            $display("[TB] FAIL min_down_wrap: got %h, want 105909", dut_time());
        end
        key_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        key_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (dut_time() !== pack_time(9, 59, 9) || field_sel !== 2'd2) begin
            bad++;
            $display("[TB] FAIL hour_down_borrow: got %h fs=%0d, want 095909 fs=2", dut_time(), field_sel);
        end
        key_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (field_sel !== 2'd0) begin
            bad++;
            $display("[TB] FAIL nav_left_wrap: got fs=%0d, want 0", field_sel);
        end
        key_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (field_sel !== 2'd2) begin
            bad++;
            $display("[TB] FAIL nav_right_wrap: got fs=%0d, want 2", field_sel);
        end
        key_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        key_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        key_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (dut_time() !== pack_time(8, 59, 9) || field_sel !== 2'd1) begin
            bad++;
            $display("[TB] FAIL hour_down_up_right: got %h fs=%0d, want 085909 fs=1", dut_time(), field_sel);
        end
        quiet_exit();
    endtask

    task automatic test_simultaneous();
        set_cur(1, 2, 3, 4, 5, 6);
        enter_edit();
        key_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        total++;
        if (dut_time() !== pack_time(12, 34, 56)) begin
            bad++;
            $display("[TB] FAIL up_down_together: got %h, want 123456", dut_time());
        end
        key_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (field_sel !== 2'd0) begin
            bad++;
            $display("[TB] FAIL left_right_together: got fs=%0d, want 0", field_sel);
        end
        key_cycle(1'b1, 1'b0, 1'b1, 1'b0);
        total++;
        if (dut_time() !== pack_time(12, 34, 57) || field_sel !== 2'd1) begin
            bad++;
            $display("[TB] FAIL up_with_left: got %h fs=%0d, want 123457 fs=1", dut_time(), field_sel);
        end
        quiet_exit();
    endtask

    task automatic test_commit();
        set_cur(0, 7, 0, 8, 0, 8);
        enter_edit();
        key_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        settime = 1'b0;
        cycle();
        total++;
        if (load !== 1'b0 || editing !== 1'b1) begin
            bad++;
            $display("[TB] FAIL commit_edge1: got ld=%b ed=%b, want 0 1", load, editing);
        end
        cycle();
        total++;
        if (load !== 1'b1 || editing !== 1'b0 || dut_time() !== pack_time(7, 8, 9)) begin
            bad++;
            $display("[TB] FAIL commit_load: got ld=%b ed=%b time=%h, want 1 0 070809", load, editing, dut_time());
        end
        set_cur(1, 1, 2, 2, 3, 3);
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (load !== 1'b0 || dut_time() !== pack_time(7, 8, 9)) begin
                bad++;
                $display("[TB] FAIL commit_hold: got ld=%b time=%h, want 0 070809", load, dut_time());
            end
        end
    endtask

    task automatic test_back_to_back();
        set_cur(0, 1, 0, 2, 0, 3);
        enter_edit();
        settime = 1'b0;
        cycle();
        settime = 1'b1;
        set_cur(0, 4, 0, 5, 0, 6);
        cycle();
        total++;
        if (load !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_load: got ld=%b, want 1", load);
        end
        cycle();
        total++;
        if (load !== 1'b0 || editing !== 1'b1 || dut_time() !== pack_time(4, 5, 6)) begin
            bad++;
            $display("[TB] FAIL b2b_reenter: got ld=%b ed=%b time=%h, want 0 1 040506", load, editing, dut_time());
        end
        quiet_exit();
    endtask

    task automatic test_blink();
        set_cur(2, 5, 3, 0, 1, 5);
        enter_edit();
        total++;
        if (dut_time() !== pack_time(0, 30, 15)) begin
            bad++;
            $display("[TB] FAIL sanitise_hour: got %h, want 003015", dut_time());
        end
        for (int i = 0; i < 10; i++) begin
            key_cycle(1'b0, 1'b0, 1'b0, 1'b0);
            total++;
            if (blink !== exp_blink()) begin
                bad++;
                $display("[TB] FAIL blink_free n=%0d: got %b, want %b", m_n, blink, exp_blink());
            end
        end
        key_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (blink !== exp_blink()) begin
                bad++;
                $display("[TB] FAIL blink_restart n=%0d: got %b, want %b", m_n, blink, exp_blink());
            end
            key_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
        quiet_exit();
        set_cur(1, 9, 6, 10, 5, 9);
        enter_edit();
        total++;
        if (dut_time() !== pack_time(19, 0, 59)) begin
            bad++;
            $display("[TB] FAIL sanitise_min: got %h, want 190059", dut_time());
        end
        quiet_exit();
    endtask

    task automatic test_random();
        logic l, r, u, d;
        for (int s = 0; s < 6; s++) begin
            if ($urandom_range(0, 4) == 0)
                set_cur($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                        $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            else
                set_cur($urandom_range(0, 2), $urandom_range(0, 9), $urandom_range(0, 5),
                        $urandom_range(0, 9), $urandom_range(0, 5), $urandom_range(0, 9));
            enter_edit();
            for (int c = 0; c < 40; c++) begin
                l = ($urandom_range(0, 5) == 0);
                r = ($urandom_range(0, 5) == 0);
                u = ($urandom_range(0, 3) == 0);
                d = ($urandom_range(0, 3) == 0);
                key_cycle(l, r, u, d);
                total++;
                if (dut_time() !== pack_time(m_h, m_m, m_s) || field_sel !== 2'(m_fs) ||
                    blink !== exp_blink() || editing !== 1'b1 || load !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL rand_edit s=%0d c=%0d: got time=%h fs=%0d bl=%b ed=%b ld=%b, want time=%h fs=%0d bl=%b ed=1 ld=0",
                             s, c, dut_time(), field_sel, blink, editing, load,
                             pack_time(m_h, m_m, m_s), m_fs, exp_blink());
                end
            end
            settime = 1'b0;
            key_cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            cycle();
            total++;
            if (load !== 1'b1 || dut_time() !== pack_time(m_h, m_m, m_s)) begin
                bad++;
                $display("[TB] FAIL rand_commit s=%0d: got ld=%b time=%h, want 1 %h",
                         s, load, dut_time(), pack_time(m_h, m_m, m_s));
            end
            cycle();
            total++;
            if (load !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rand_single_load s=%0d: got ld=%b, want 0", s, load);
            end
            cycle();
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_rollover();
        test_field_nav();
        test_simultaneous();
        test_commit();
        test_back_to_back();
        test_blink();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Keyboard-driven time-edit controller that sits between the four kb_controller key outputs (left/right/up/down) and the time counter's load path. On entry to set mode it snapshots the running time. Arrow keys then select and adjust the hour, minute or second field in BCD. On exit it emits a one-cycle load strobe carrying the edited time. It also drives field-select and blink outputs so the seven-segment and VGA stages can highlight the field being edited.

Parameters:
BLINK_HALF, 25000000, clk cycles per blink half-period (0.25 s at 100 MHz)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
settime  in  1  set-mode level; high = edit
left_key  in  1  one-cycle pulse; select next field toward hours
right_key  in  1  one-cycle pulse; select next field toward seconds
up_key  in  1  one-cycle pulse; increment selected field
down_key  in  1  one-cycle pulse; decrement selected field
cur_secMSB, cur_secLSB, cur_minMSB, cur_minLSB, cur_hourMSB, cur_hourLSB  in  4 each  running time, BCD
set_secMSB, set_secLSB, set_minMSB, set_minLSB, set_hourMSB, set_hourLSB  out  4 each  edited time, BCD
field_sel  out  2  0 = seconds, 1 = minutes, 2 = hours (3 never driven)
editing  out  1  high while in EDIT
blink  out  1  highlight phase for the selected field
load  out  1  one-cycle strobe; set_* valid to load into counter

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high.
- Reset, including mid-edit: all state and outputs return to their reset values:
  - state = IDLE
  - all set_* digits = 0
  - field_sel = 0
  - editing = 0, blink = 0, load = 0
  - settime_q = 0
  - no load is issued.
- settime is registered into settime_q each cycle.
  - rise = settime & ~settime_q
  - fall = ~settime & settime_q
- States are IDLE, EDIT and COMMIT.
- IDLE:
  - editing = 0, blink = 0; key pulses are ignored.
  - On rise, in the next cycle: snapshot cur_* into set_*, set field_sel = 0, clear the blink counter, set blink = 1, and move to EDIT.
  - Snapshot sanitising: a field whose value is not valid BCD or is out of range (sec/min > 59, hour > 23, or any digit > 9) is loaded as 00.
- EDIT:
  - editing = 1.
  - Field select:
    - left_key: field_sel 0→1→2→0.
    - right_key: field_sel 2→1→0→2.
    - left_key and right_key in the same cycle: no change.
  - Increment/decrement of the selected field, BCD arithmetic:
    - up_key: sec/min 59→00, hour 23→00, otherwise +1 with LSB carry 9→0 into MSB.
    - down_key: sec/min 00→59, hour 00→23, otherwise −1 with LSB borrow 0→9 from MSB.
    - up_key and down_key in the same cycle: no change.
  - Value and field key in the same cycle: the value change applies to the old field_sel; the new field_sel takes effect next cycle.
  - Latency: set_* and field_sel update on the clock edge after the key pulse is sampled (1 cycle).
  - Blink:
    - A counter counts to BLINK_HALF−1, then toggles blink and wraps to 0.
    - Any key pulse resets the counter and forces blink = 1.
  - On fall → COMMIT. Key pulses in the same cycle as fall are still applied.
- COMMIT:
  - Lasts exactly 1 cycle: load = 1, editing = 0, blink = 0, set_* held.
  - Next state is IDLE.
  - If settime is already high again in this cycle, it is detected as a new rise from IDLE on the following cycle.
- set_* holds its last edited value in IDLE and only changes on snapshot or in EDIT.
- load is never high for more than one consecutive cycle.

Test Plan:
1. Assert reset mid-EDIT with set_* = 12:34:56 → next cycle: all set_* = 0, field_sel = 0, editing = 0, and load never pulses.
2. cur = 23:59:58, raise settime → one cycle later: editing = 1, set = 23:59:58, field_sel = 0, blink = 1; then up ×2 → set_sec = 00, with no carry into minutes.
3. Snapshot 10:00:09; press left (field_sel = 1); down → set = 10:59:09; left, down → set = 09:59:09; left → field_sel = 0.
4. In EDIT, pulse up_key and down_key in the same cycle → set_* unchanged. Pulse up_key and left_key together with field_sel = 0 → seconds +1, field_sel = 1.
5. Lower settime after editing to 07:08:09 → exactly one load pulse, 2 cycles after the fall edge on the input, with set = 07:08:09. editing falls in the same cycle, and set_* holds afterwards.
6. BLINK_HALF = 4 in EDIT with no keys → blink toggles every 4 cycles. A key pulse restarts the count with blink = 1. Snapshot of cur hour = 25 loads hour 00.
